cic_integrator_bank: RTL
========================

# cic_integrator_bank

Multi-channel, time-multiplexed integrator cascade for the CIC decimator front end. It is the generalised replacement for the single-channel fixed-width integrator chain.
- Holds M pipelined integrator stages, each with independent state for CH interleaved channels.
- Sign-extends input samples to a wider accumulator width to absorb CIC bit growth.
- Adds a global stall for downstream backpressure.
- Sits between the input sample mux and the decimator/comb section.

## Interface
- M, 3: number of cascaded integrator stages; M >= 1
- IN_BITS, 10: input sample width, two's complement
- OUT_BITS, 22: accumulator/output width; OUT_BITS >= IN_BITS; set to IN_BITS + M*ceil(log2(R*D)) by the integrator
- CH, 4: number of interleaved channels; CH >= 1
- CH_BITS, derived: max(1, $clog2(CH)); not to be overridden
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stream_in  input  IN_BITS  signed input sample
- channel_in  input  CH_BITS  channel index of stream_in
- valid  input  1  stream_in/channel_in valid this cycle
- stall  input  1  downstream backpressure; freezes the block
- accept  output  1  combinational !stall; sample is taken when valid && accept
- stream_out  output  OUT_BITS  signed integrated sample, stage M-1 result
- channel_out  output  CH_BITS  channel index of stream_out
- ready  output  1  stream_out/channel_out valid this cycle

## Operation
- State: acc[m][c] for m in 0..M-1 and c in 0..CH-1, each OUT_BITS wide, held in registers (no RAM).
- Each stage m has a pipeline register holding data_m, chan_m and vld_m.
- Stage 0 input is sign_extend(stream_in) tagged with channel_in and valid.
- Stage m>0 input is the stage m-1 pipeline register.
- Per stage per cycle, when !stall and input valid with channel c:
  - sum = acc[m][c] + x, computed modulo 2^OUT_BITS; wrap-around is required for CIC correctness, with no saturation.
  - acc[m][c] <= sum; data_m <= sum; chan_m <= c; vld_m <= 1.
- When the stage input is invalid and !stall: vld_m <= 0; data_m, chan_m and all acc[m][*] hold.
- A sample with channel_in >= CH is dropped. It causes no state change and is treated as invalid at stage 0.
- Same-channel samples on consecutive cycles are legal. Each stage performs its read-modify-write in one cycle, so no hazard exists.
- stall=1: every register (acc, data, chan, vld) holds; input is not taken; outputs are stable.
- Outputs: stream_out=data_{M-1}, channel_out=chan_{M-1}, ready=vld_{M-1}.

## Timing
- Latency M cycles from accepted input to ready, with no stall. With stall, latency is M plus the number of stalled cycles.
- Throughput: one sample per cycle, any channel order.
- Reset (async assert; release is synchronous to clk externally):
  - all acc = 0, data = 0, chan = 0, vld = 0
  - stream_out = 0, channel_out = 0, ready = 0
  - accept follows stall.
- Reset mid-operation discards all in-flight samples and all channel state immediately. No ready pulse occurs until M cycles after the first accepted sample following release.
- stall and valid together: the sample is not taken. The source must hold it until accept=1.

## Configuration
- CIC_INT_CLEAR_EN defined: adds port clear (input, 1), a synchronous clear.
  - clear=1 at a clock edge zeroes all acc, data and vld, overriding stall and any valid input (that sample is discarded).
  - Outputs read 0 and ready=0 on the next cycle.
- CIC_INT_CLEAR_EN not defined: no clear port. State is cleared only by rst.

## Test plan
- M=1, CH=1, IN_BITS=10, OUT_BITS=22, stream_in=1 valid every cycle: ready rises 1 cycle after the first input; stream_out = 1,2,3,4,…
- M=2, CH=1, impulse 1 then 0s: ready after 2 cycles; stream_out = 1,2,3,4,… (discrete ramp).
- M=1, CH=4, round-robin channels 0..3 with inputs 10,20,30,40 repeated:
  - channel_out = 0,1,2,3,…
  - stream_out = 10,20,30,40,20,40,60,80,…
  - a channel_in=5 sample inserted mid-stream is dropped with no ready pulse, and later channel-0 outputs are unaffected.
- Wrap: M=1, CH=1, IN_BITS=8, OUT_BITS=8, input 127 repeated: stream_out = 127, -2 (0xFE), 125 (0x7D), …
- Stall: M=3, CH=1, constant input 1, stall held 3 cycles mid-stream: accept=0 and outputs frozen during the stall; the sequence resumes with no lost or duplicated values.
- Reset mid-stream plus clear:
  - Assert rst asynchronously: ready=0 and stream_out=0 immediately; restarting with input 1 reproduces 1,2,3.
  - With CIC_INT_CLEAR_EN, a clear pulse has the same effect synchronously.

Source files
------------

// File: rtl/cic_integrator_bank_if.sv
// Sample stream bundle for cic_integrator_bank: input samples, backpressure and integrated output.
// The clear line exists only when CIC_INT_CLEAR_EN is defined.
interface cic_integrator_bank_if #(
  parameter int IN_BITS  = 10,
  parameter int OUT_BITS = 22,
  parameter int CH       = 4
);
  localparam int CH_BITS = (CH > 1) ? $clog2(CH) : 1;

  logic [IN_BITS-1:0]  stream_in;
  logic [CH_BITS-1:0]  channel_in;
  logic                valid;
  logic                stall;
  logic                accept;
  logic [OUT_BITS-1:0] stream_out;
  logic [CH_BITS-1:0]  channel_out;
  logic                ready;
`ifdef CIC_INT_CLEAR_EN
  logic                clear;

  modport master (output stream_in, channel_in, valid, stall, clear,
                  input  accept, stream_out, channel_out, ready);
  modport slave  (input  stream_in, channel_in, valid, stall, clear,
                  output accept, stream_out, channel_out, ready);
`else
  modport master (output stream_in, channel_in, valid, stall,
                  input  accept, stream_out, channel_out, ready);
  modport slave  (input  stream_in, channel_in, valid, stall,
                  output accept, stream_out, channel_out, ready);
`endif
endinterface

// File: rtl/cic_integrator_bank.sv
// Time-multiplexed M-stage CIC integrator cascade with CH independent channel states per stage.
// Optional synchronous clear input enabled by defining CIC_INT_CLEAR_EN.
module cic_integrator_bank #(
  parameter int M        = 3,
  parameter int IN_BITS  = 10,
  parameter int OUT_BITS = 22,
  parameter int CH       = 4
) (
  input logic                 clk,
  input logic                 rst,
  cic_integrator_bank_if.slave bus
);
  localparam int CH_BITS = (CH > 1) ? $clog2(CH) : 1;

  function automatic logic [OUT_BITS-1:0] sign_extend(input logic [IN_BITS-1:0] v);
    return OUT_BITS'(signed'(v));
  endfunction

  logic [OUT_BITS-1:0] acc_r  [M][CH];
  logic [OUT_BITS-1:0] data_r [M];
  logic [CH_BITS-1:0]  chan_r [M];
  logic [M-1:0]        vld_r;

  logic [OUT_BITS-1:0] x_s   [M];
  logic [CH_BITS-1:0]  xc_s  [M];
  logic [M-1:0]        xv_s;
  logic [OUT_BITS-1:0] sum_s [M];

  // Stage inputs and per-stage read-modify-write sums (wrapping adds, no saturation)
  always_comb begin
    logic [OUT_BITS-1:0] sel;
    x_s[0]  = sign_extend(bus.stream_in);
    xc_s[0] = bus.channel_in;
    // Out-of-range channel indices are treated as no sample at all
    xv_s[0] = bus.valid && (32'(bus.channel_in) < 32'(CH));
    for (int m = 1; m < M; m++) begin
      x_s[m]  = data_r[m-1];
      xc_s[m] = chan_r[m-1];
      xv_s[m] = vld_r[m-1];
    end
    for (int m = 0; m < M; m++) begin
      sel = '0;
      for (int c = 0; c < CH; c++) begin
        if (xc_s[m] == CH_BITS'(c)) begin
          sel = acc_r[m][c];
        end else begin
          sel = sel;
        end
      end
      sum_s[m] = sel + x_s[m];
    end
  end

  // Accumulator and pipeline state; stall freezes every register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < M; m++) begin
        for (int c = 0; c < CH; c++) begin
          acc_r[m][c] <= '0;
        end
        data_r[m] <= '0;
        chan_r[m] <= '0;
      end
      vld_r <= '0;
    end
`ifdef CIC_INT_CLEAR_EN
    else if (bus.clear) begin
      for (int m = 0; m < M; m++) begin
        for (int c = 0; c < CH; c++) begin
          acc_r[m][c] <= '0;
        end
        data_r[m] <= '0;
        chan_r[m] <= '0;
      end
      vld_r <= '0;
    end
`endif
    else if (!bus.stall) begin
      for (int m = 0; m < M; m++) begin
        if (xv_s[m]) begin
          for (int c = 0; c < CH; c++) begin
            if (xc_s[m] == CH_BITS'(c)) begin
              acc_r[m][c] <= sum_s[m];
            end
          end
          data_r[m] <= sum_s[m];
          chan_r[m] <= xc_s[m];
          vld_r[m]  <= 1'b1;
        end else begin
          vld_r[m]  <= 1'b0;
        end
      end
    end
  end

  assign bus.accept      = !bus.stall;
  assign bus.stream_out  = data_r[M-1];
  assign bus.channel_out = chan_r[M-1];
  assign bus.ready       = vld_r[M-1];
endmodule
